instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
- Upstream of instruction_memory. Receives the program as a byte stream from the debug UART receiver and assembles 4-byte instruction words.
- Drives the memory write port, one word per write pulse, at consecutive word addresses starting at 0.
- Stops on the HALT word or when memory is full, then signals load completion to the debug unit, which releases the pipeline.

Parameters:
- PC_WIDTH, 9, word-address width of instruction memory.
- NB_WIDTH, 32, instruction width. Fixed at 32; four bytes per word.
- NB_BYTE, 8, receive data width.
- HALT_WORD, 32'hFFFF_FFFF, end-of-program marker. It is written to memory, then loading stops.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse; begin a load. Ignored unless in IDLE or DONE.
- i_abort  in  1  return to IDLE from any state next cycle; no further writes.
- i_rx_data  in  NB_BYTE  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid.
- o_write_enable  out  1  write pulse to instruction memory.
- o_address  out  PC_WIDTH  word address for the write.
- o_write_data  out  NB_WIDTH  instruction word for the write.
- o_busy  out  1  high in RECV and WRITE.
- o_load_done  out  1  high while in DONE.
- o_full  out  1  sticky: load ended by running out of memory, not by HALT.
- o_word_count  out  PC_WIDTH+1  number of words written in the current or last load.

Behaviour:
- Reset: i_reset_n=0 asynchronously forces state IDLE and clears byte index, address, o_write_enable, o_write_data, o_busy, o_load_done, o_full and o_word_count to 0. Reset mid-load abandons the partial word.
- States:
  - IDLE: wait for i_start. On i_start, clear address, byte index, count and o_full, then go to RECV.
  - RECV: on each i_rx_valid, shift the byte into the assembly register, first byte into the MSB (big-endian), and increment the byte index. On the 4th byte, load o_write_data with the complete word and go to WRITE next cycle. Bytes arriving while not in RECV are dropped.
  - WRITE: o_write_enable=1 for exactly one cycle, with o_address = current address. The same edge increments o_word_count. Next state:
    - word == HALT_WORD → DONE.
    - else address == DEPTH-1 → DONE, set o_full.
    - else increment the address → RECV.
  - DONE: o_load_done=1. Address and count are held. i_start restarts the load (goes to RECV, counters cleared).
- Latency: o_write_enable asserts on the cycle after the edge that samples the 4th i_rx_valid.
- An i_rx_valid arriving in the WRITE cycle is accepted as byte 0 of the next word; it must not be lost. Exception: if that WRITE ends the load (HALT or full), the byte is dropped.
- Outputs are registered. o_address and o_write_data are stable throughout the write pulse.
- Simultaneous events:
  - i_abort has priority over i_start and i_rx_valid.
  - i_start while in RECV or WRITE is ignored.
- Address wrap never occurs; full detection stops the load first. o_word_count reaches DEPTH exactly when full.

Decomposition:
- Shared pipeline package (pipeline_defs):
  - loader state encoding: IDLE=2'd0, RECV=2'd1, WRITE=2'd2, DONE=2'd3.
  - HALT_WORD constant.
  - PC_WIDTH / NB_WIDTH defaults shared with instruction_memory.
- One natural sub-module: byte_assembler. It holds the shift register and 2-bit byte index, outputs word_valid, and clears on a clear input.
- The FSM and address counter stay in the top module.

Test Plan:
- Reset: hold i_reset_n=0 mid-RECV after 2 bytes, release, send i_start plus bytes 12,34,56,78 → single write of 32'h12345678 at addr 0. No stale bytes.
- Normal load: i_start, then bytes 20 08 00 05, 00 00 00 00, FF FF FF FF → writes 32'h20080005@0, 32'h00000000@1, 32'hFFFFFFFF@2; o_load_done=1, o_word_count=3, o_full=0. Connect instruction_memory and read back all three.
- Back-to-back bytes: i_rx_valid every cycle, including the WRITE cycle → no bytes lost; 5 non-halt words land at addrs 0–4 with the correct values.
- Full: send 512 non-halt words (PC_WIDTH=9) → last write at addr 511, o_full=1, o_word_count=512. The 513th word's bytes are ignored and cause no write.
- Abort: i_abort after byte 3 of word 1 → IDLE next cycle, no write for word 1. A later 4th byte causes no write; word 0 remains in memory.
- Restart: from DONE, i_start then one HALT word → write at addr 0, o_word_count=1, o_full cleared.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: widths, end-of-program marker
// and the loader state encoding.
package instruction_loader_pkg;

  localparam int DEF_PC_WIDTH = 9;
  localparam int DEF_NB_WIDTH = 32;
  localparam int DEF_NB_BYTE  = 8;

  localparam logic [DEF_NB_WIDTH-1:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_RECV  = 2'd1,
    LD_WRITE = 2'd2,
    LD_DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// Collects big-endian bytes into one word; word_valid_o flags the byte that
// completes the word, with word_o carrying the full word in that same cycle.
module instruction_loader_byte_assembler #(
  parameter int NB_WIDTH = 32,
  parameter int NB_BYTE  = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                byte_valid_i,
  input  logic [NB_BYTE-1:0]  byte_i,
  output logic [NB_WIDTH-1:0] word_o,
  output logic                word_valid_o
);

  logic [NB_WIDTH-NB_BYTE-1:0] shift_q;
  logic [1:0]                  index_q;

  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = byte_valid_i && !clear_i && (index_q == 2'd3);

  // Older bytes fall off the top, so the register never needs clearing between words.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      index_q <= 2'd0;
    end else if (clear_i) begin
      shift_q <= '0;
      index_q <= 2'd0;
    end else if (byte_valid_i) begin
      shift_q <= {shift_q[NB_WIDTH-2*NB_BYTE-1:0], byte_i};
      index_q <= index_q + 2'd1;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Assembles the UART byte stream into instruction words and writes them to
// consecutive memory addresses until HALT or memory full.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int                  PC_WIDTH  = DEF_PC_WIDTH,
  parameter int                  NB_WIDTH  = DEF_NB_WIDTH,
  parameter int                  NB_BYTE   = DEF_NB_BYTE,
  parameter logic [NB_WIDTH-1:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_valid,
  output logic                o_write_enable,
  output logic [PC_WIDTH-1:0] o_address,
  output logic [NB_WIDTH-1:0] o_write_data,
  output logic                o_busy,
  output logic                o_load_done,
  output logic                o_full,
  output logic [PC_WIDTH:0]   o_word_count,
  output loader_state_e       o_state
);

  localparam logic [PC_WIDTH:0]   CNT_ONE  = {{PC_WIDTH{1'b0}}, 1'b1};
  localparam logic [PC_WIDTH-1:0] ADDR_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PC_WIDTH-1:0] ADDR_MAX = {PC_WIDTH{1'b1}};

  loader_state_e       state_q, state_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic [PC_WIDTH:0]   count_q, count_d;
  logic                full_q, full_d;
  logic [NB_WIDTH-1:0] data_q, data_d;
  logic                we_q, busy_q, done_q;

  logic                asm_clear;
  logic                byte_accept;
  logic [NB_WIDTH-1:0] asm_word;
  logic                asm_word_valid;

  // The rx strobe has no backpressure: a byte is either accepted in the cycle
  // i_rx_valid is high (RECV, or a WRITE that continues the load) or lost.
  instruction_loader_byte_assembler #(
    .NB_WIDTH (NB_WIDTH),
    .NB_BYTE  (NB_BYTE)
  ) u_byte_assembler (
    .clk_i        (i_clk),
    .rst_ni       (i_reset_n),
    .clear_i      (asm_clear),
    .byte_valid_i (byte_accept),
    .byte_i       (i_rx_data),
    .word_o       (asm_word),
    .word_valid_o (asm_word_valid)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    full_d      = full_q;
    data_d      = data_q;
    asm_clear   = 1'b0;
    byte_accept = 1'b0;

    if (i_abort) begin
      state_d   = LD_IDLE;
      asm_clear = 1'b1;
    end else begin
      case (state_q)
        LD_IDLE, LD_DONE: begin
          if (i_start) begin
            state_d   = LD_RECV;
            addr_d    = '0;
            count_d   = '0;
            full_d    = 1'b0;
            asm_clear = 1'b1;
          end
        end
        LD_RECV: begin
          byte_accept = i_rx_valid;
          if (asm_word_valid) begin
            data_d  = asm_word;
            state_d = LD_WRITE;
          end
        end
        LD_WRITE: begin
          count_d = count_q + CNT_ONE;
          if (data_q == HALT_WORD) begin
            state_d = LD_DONE;
          end else if (addr_q == ADDR_MAX) begin
            state_d = LD_DONE;
            full_d  = 1'b1;
          end else begin
            // The load continues, so a byte landing in the write cycle opens the next word.
            addr_d      = addr_q + ADDR_ONE;
            state_d     = LD_RECV;
            byte_accept = i_rx_valid;
          end
        end
        default: state_d = LD_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= LD_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      full_q  <= full_d;
      data_q  <= data_d;
      we_q    <= (state_d == LD_WRITE);
      busy_q  <= (state_d == LD_RECV) || (state_d == LD_WRITE);
      done_q  <= (state_d == LD_DONE);
    end
  end

  assign o_write_enable = we_q;
  assign o_address      = addr_q;
  assign o_write_data   = data_q;
  assign o_busy         = busy_q;
  assign o_load_done    = done_q;
  assign o_full         = full_q;
  assign o_word_count   = count_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: vector tables for word loads plus
// hand-written reset, full, restart and abort sequences.
module tb_instruction_loader;
  import instruction_loader_pkg::*;

  localparam int PCW = 9;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start, abort, rx_valid;
  logic [7:0]     rx_data;
  logic           we;
  logic [PCW-1:0] addr;
  logic [31:0]    wdata;
  logic           busy, done, full;
  logic [PCW:0]   count;
  loader_state_e  state;

  always #5 clk = ~clk;

  instruction_loader dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_start        (start),
    .i_abort        (abort),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_write_enable (we),
    .o_address      (addr),
    .o_write_data   (wdata),
    .o_busy         (busy),
    .o_load_done    (done),
    .o_full         (full),
    .o_word_count   (count),
    .o_state        (state)
  );

  int          tests_run = 0;
  int          tests_failed = 0;
  int          writes_seen = 0;
  logic [40:0] exp_q[$];
  logic [31:0] mem [512];

  typedef struct {
    logic [31:0]    word;
    int             gap;
    logic [PCW-1:0] exp_addr;
    logic           exp_done;
  } vec_t;

  vec_t        nv[3];
  logic [31:0] b2b[6];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write scoreboard: every write pulse must match the head of exp_q.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && we === 1'b1) begin
      writes_seen++;
      mem[addr] = wdata;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", addr, wdata);
      end else begin
        check("write_addr_data", {23'd0, addr, wdata}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic idle(int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_byte(logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
  endtask

  task automatic send_word(logic [31:0] w, int gap);
    for (int k = 0; k < 4; k++) begin
      drive_byte(w[31-8*k -: 8]);
      if (k < 3 && gap > 0) idle(gap);
    end
    rx_valid = 1'b0;
  endtask

  task automatic stream_word(logic [31:0] w);
    for (int k = 0; k < 4; k++) drive_byte(w[31-8*k -: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    writes_seen = 0;
  endtask

  task automatic wait_done(int budget, string name);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'd0, done}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    nv[0] = '{word: 32'h2008_0005, gap: 0, exp_addr: 9'd0, exp_done: 1'b0};
    nv[1] = '{word: 32'h0000_0000, gap: 2, exp_addr: 9'd1, exp_done: 1'b0};
    nv[2] = '{word: 32'hFFFF_FFFF, gap: 1, exp_addr: 9'd2, exp_done: 1'b1};
    b2b = '{32'h0102_0304, 32'hDEAD_BEEF, 32'h0000_00FF, 32'hFF00_FF00, 32'h7FFF_FFFF,
            32'hFFFF_FFFF};

    // Reset values while reset is held
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_we", {63'd0, we}, 64'd0);
    check("rst_addr", {55'd0, addr}, 64'd0);
    check("rst_data", {32'd0, wdata}, 64'd0);
    check("rst_busy_done_full", {61'd0, busy, done, full}, 64'd0);
    check("rst_count", {54'd0, count}, 64'd0);
    check("rst_state", {62'd0, state}, {62'd0, LD_IDLE});

    // Reset in the middle of a word drops the partial bytes
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    drive_byte(8'hAA);
    drive_byte(8'hBB);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_async_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    writes_seen = 0;
    pulse_start();
    exp_q.push_back({9'd0, 32'h1234_5678});
    send_word(32'h1234_5678, 0);
    check("midreset_we_latency", {63'd0, we}, 64'd1);
    idle(3);
    check("midreset_single_write", writes_seen, 1);
    check("midreset_count", {54'd0, count}, 64'd1);
    check("midreset_still_recv", {62'd0, state}, {62'd0, LD_RECV});

    // Normal load from the vector table
    do_reset();
    pulse_start();
    check("start_busy", {63'd0, busy}, 64'd1);
    foreach (nv[i]) begin
      exp_q.push_back({nv[i].exp_addr, nv[i].word});
      send_word(nv[i].word, nv[i].gap);
      check("norm_we", {63'd0, we}, 64'd1);
      check("norm_addr", {55'd0, addr}, {55'd0, nv[i].exp_addr});
      check("norm_data", {32'd0, wdata}, {32'd0, nv[i].word});
      idle(1);
      check("norm_we_one_cycle", {63'd0, we}, 64'd0);
      check("norm_done", {63'd0, done}, {63'd0, nv[i].exp_done});
    end
    idle(2);
    check("norm_count", {54'd0, count}, 64'd3);
    check("norm_full", {63'd0, full}, 64'd0);
    check("norm_busy", {63'd0, busy}, 64'd0);
    foreach (nv[i]) check("norm_readback", {32'd0, mem[nv[i].exp_addr]}, {32'd0, nv[i].word});
    check("norm_writes", writes_seen, 3);
    check("norm_exp_empty", exp_q.size(), 0);

    // Back-to-back bytes, including the write cycles
    do_reset();
    pulse_start();
    foreach (b2b[i]) begin
      exp_q.push_back({i[8:0], b2b[i]});
      stream_word(b2b[i]);
    end
    rx_valid = 1'b0;
    wait_done(20, "b2b_done");
    idle(1);
    check("b2b_count", {54'd0, count}, 64'd6);
    check("b2b_writes", writes_seen, 6);
    foreach (b2b[i]) check("b2b_readback", {32'd0, mem[i]}, {32'd0, b2b[i]});
    check("b2b_exp_empty", exp_q.size(), 0);

    // Fill memory; the 513th word must be ignored
    do_reset();
    pulse_start();
    for (int i = 0; i < 513; i++) begin
      logic [31:0] w;
      w = {16'hA5C3, 16'(i)};
      if (i < 512) exp_q.push_back({9'(i), w});
      stream_word(w);
    end
    rx_valid = 1'b0;
    wait_done(20, "full_done");
    idle(3);
    check("full_flag", {63'd0, full}, 64'd1);
    check("full_count", {54'd0, count}, 64'd512);
    check("full_last_addr", {55'd0, addr}, 64'd511);
    check("full_writes", writes_seen, 512);
    check("full_mem_last", {32'd0, mem[511]}, {32'd0, 32'hA5C3_01FF});
    check("full_exp_empty", exp_q.size(), 0);

    // Restart from DONE with a lone HALT word
    writes_seen = 0;
    pulse_start();
    check("restart_full_cleared", {63'd0, full}, 64'd0);
    check("restart_count_cleared", {54'd0, count}, 64'd0);
    exp_q.push_back({9'd0, 32'hFFFF_FFFF});
    send_word(32'hFFFF_FFFF, 0);
    check("restart_addr", {55'd0, addr}, 64'd0);
    idle(2);
    check("restart_done", {63'd0, done}, 64'd1);
    check("restart_count", {54'd0, count}, 64'd1);
    check("restart_full", {63'd0, full}, 64'd0);
    check("restart_writes", writes_seen, 1);

    // Abort partway through word 1
    do_reset();
    pulse_start();
    exp_q.push_back({9'd0, 32'h1122_3344});
    send_word(32'h1122_3344, 0);
    idle(1);
    drive_byte(8'h55);
    drive_byte(8'h66);
    drive_byte(8'h77);
    rx_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_state", {62'd0, state}, {62'd0, LD_IDLE});
    check("abort_busy", {63'd0, busy}, 64'd0);
    drive_byte(8'h88);
    idle(3);
    check("abort_writes", writes_seen, 1);
    check("abort_mem0", {32'd0, mem[0]}, {32'd0, 32'h1122_3344});
    check("abort_exp_empty", exp_q.size(), 0);

    // Abort wins over a simultaneous start
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_over_start", {62'd0, state}, {62'd0, LD_IDLE});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
